// File: rtl/uart_tx_frame_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } uart_parity_t;

  typedef enum logic [1:0] {
    STOP_1,
    STOP_1P5,
    STOP_2
  } uart_stop_t;

  // Length of the stop period in oversample ticks.
  function automatic int uart_stop_ticks(uart_stop_t mode, int oversample);
    case (mode)
      STOP_1:   return oversample;
      STOP_1P5: return (3 * oversample) / 2;
      default:  return 2 * oversample;
    endcase
  endfunction

  // Raw parity code to mode; the spare code 11 means no parity.
  function automatic uart_parity_t uart_decode_parity(logic [1:0] code);
    case (code)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // Raw stop code to mode; 10 and 11 both select two stop bits.
  function automatic uart_stop_t uart_decode_stop(logic [1:0] code);
    case (code)
      2'b00:   return STOP_1;
      2'b01:   return STOP_1P5;
      default: return STOP_2;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side word handshake plus per-frame configuration.
interface uart_tx_frame_if #(
  parameter int MAX_DBIT = 8
);
  logic                tx_valid;
  logic [MAX_DBIT-1:0] tx_data;
  logic                tx_ready;
  logic [3:0]          cfg_dbits;
  logic [1:0]          cfg_parity;
  logic [1:0]          cfg_stop;

  modport master (
    output tx_valid, tx_data, cfg_dbits, cfg_parity, cfg_stop,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_data, cfg_dbits, cfg_parity, cfg_stop,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_hold.sv
// One-entry holding register between the host and the frame shifter.
module uart_tx_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // Fill on handshake, empty when the transmitter loads a frame.
  // The two never coincide: a push needs !full, a pop needs full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (push_valid && !full) begin
      full <= 1'b1;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // Ready is a pure decode of the flop so it never depends on valid.
  assign push_ready = !full;

endmodule

// File: rtl/uart_tx_frame.sv
// Runtime-configurable UART transmitter with a one-word holding register.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int MAX_DBIT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  uart_tx_frame_if.slave   bus,
  output logic             tx_busy,
  output logic             tx_done_tick,
  output logic             tx
);

  localparam int SW = $clog2(2 * OVERSAMPLE);
  localparam int NW = $clog2(MAX_DBIT);
  localparam logic [SW-1:0] BIT_LAST = SW'(OVERSAMPLE - 1);

  uart_tx_state_t      state;
  logic [SW-1:0]       s;
  logic [NW-1:0]       n;
  logic [MAX_DBIT-1:0] shift;
  logic [NW-1:0]       frame_last_bit;
  logic                frame_par_en;
  logic                frame_par_bit;
  logic [SW-1:0]       frame_stop_last;
  logic                tx_reg;

  logic                hold_full;
  logic [MAX_DBIT-1:0] hold_data;
  logic                load;
  logic                stop_end;

  int                  eff_dbits;
  logic [MAX_DBIT-1:0] data_mask;
  uart_parity_t        cfg_par_mode;
  logic                cfg_par_bit;

  uart_tx_hold #(.WIDTH(MAX_DBIT)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.tx_valid),
    .push_data  (bus.tx_data),
    .push_ready (bus.tx_ready),
    .pop        (load),
    .data       (hold_data),
    .full       (hold_full)
  );

  // Out-of-range widths fall back to the full data width.
  assign eff_dbits = (int'(bus.cfg_dbits) < 5 || int'(bus.cfg_dbits) > MAX_DBIT)
                     ? MAX_DBIT : int'(bus.cfg_dbits);

  // Mask off data bits that will not be sent so they do not affect parity.
  generate
    for (genvar gi = 0; gi < MAX_DBIT; gi++) begin : g_mask
      assign data_mask[gi] = (gi < eff_dbits);
    end
  endgenerate

  // Parity is fixed at load time from the held word and the latched mode.
  assign cfg_par_mode = uart_decode_parity(bus.cfg_parity);
  assign cfg_par_bit  = (^(hold_data & data_mask)) ^ (cfg_par_mode == PAR_ODD);

  assign stop_end     = (state == STOP) && s_tick && (s == frame_stop_last);
  assign load         = hold_full && ((state == IDLE) || stop_end);
  assign tx_done_tick = stop_end;
  assign tx_busy      = (state != IDLE);
  assign tx           = tx_reg;

  // Frame sequencer: loads a word, walks start/data/parity/stop and drives tx
  // from the state being entered so the line changes on the bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      s               <= '0;
      n               <= '0;
      shift           <= '0;
      frame_last_bit  <= '0;
      frame_par_en    <= 1'b0;
      frame_par_bit   <= 1'b0;
      frame_stop_last <= '0;
      tx_reg          <= 1'b1;
    end else if (load) begin
      state           <= START;
      s               <= '0;
      n               <= '0;
      shift           <= hold_data;
      frame_last_bit  <= NW'(eff_dbits - 1);
      frame_par_en    <= (cfg_par_mode != PAR_NONE);
      frame_par_bit   <= cfg_par_bit;
      frame_stop_last <= SW'(uart_stop_ticks(uart_decode_stop(bus.cfg_stop), OVERSAMPLE) - 1);
      tx_reg          <= 1'b0;
    end else if (s_tick) begin
      case (state)
        START: begin
          if (s == BIT_LAST) begin
            state  <= DATA;
            s      <= '0;
            n      <= '0;
            tx_reg <= shift[0];
          end else begin
            s <= s + SW'(1);
          end
        end
        DATA: begin
          if (s == BIT_LAST) begin
            s     <= '0;
            shift <= shift >> 1;
            if (n == frame_last_bit) begin
              if (frame_par_en) begin
                state  <= PARITY;
                tx_reg <= frame_par_bit;
              end else begin
                state  <= STOP;
                tx_reg <= 1'b1;
              end
            end else begin
              n      <= n + NW'(1);
              tx_reg <= shift[1];
            end
          end else begin
            s <= s + SW'(1);
          end
        end
        PARITY: begin
          if (s == BIT_LAST) begin
            state  <= STOP;
            s      <= '0;
            tx_reg <= 1'b1;
          end else begin
            s <= s + SW'(1);
          end
        end
        STOP: begin
          // A pending word at this point is taken by the load branch.
          if (s == frame_stop_last) begin
            state  <= IDLE;
            s      <= '0;
            tx_reg <= 1'b1;
          end else begin
            s <= s + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised-tick bench for uart_tx_frame against a per-tick line model.
module tb_uart_tx_frame;
  localparam int OS = 16;
  localparam int MD = 8;

  logic clk = 1'b0;
  logic rst;
  logic s_tick;
  logic tx_busy;
  logic tx_done_tick;
  logic tx;

  uart_tx_frame_if #(.MAX_DBIT(MD)) bus ();

  uart_tx_frame #(.OVERSAMPLE(OS), .MAX_DBIT(MD)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .bus          (bus.slave),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_q[$];    // expected line level, one entry per s_tick
  bit last_q[$];   // 1 on the final tick of each frame
  bit pending = 0; // a second word sits in the holding register
  bit scramble = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: the line as a sequence of levels, each tick-accurate.
  task automatic model_frame(input logic [MD-1:0] d, input int dbits, input int par, input int stp);
    int db;
    int stop_ticks;
    bit x;
    db = (dbits < 5 || dbits > MD) ? MD : dbits;
    stop_ticks = (stp == 0) ? OS : (stp == 1) ? (3 * OS) / 2 : 2 * OS;
    x = 1'b0;
    for (int t = 0; t < OS; t++) begin exp_q.push_back(1'b0); last_q.push_back(1'b0); end
    for (int i = 0; i < db; i++) begin
      x ^= d[i];
      for (int t = 0; t < OS; t++) begin exp_q.push_back(d[i]); last_q.push_back(1'b0); end
    end
    if (par == 1 || par == 2)
      for (int t = 0; t < OS; t++) begin exp_q.push_back(par == 1 ? x : !x); last_q.push_back(1'b0); end
    for (int t = 0; t < stop_ticks; t++) begin
      exp_q.push_back(1'b1);
      last_q.push_back(t == stop_ticks - 1);
    end
    $display("frame data=%0h dbits=%0d parity=%0d stop=%0d ticks=%0d", d, db, par, stp,
             OS * (1 + db + ((par == 1 || par == 2) ? 1 : 0)) + stop_ticks);
  endtask

  // Hand one word over; when the line is idle also check the load latency.
  task automatic send(input logic [MD-1:0] d, input logic [3:0] db, input logic [1:0] par,
                      input logic [1:0] stp, input bit from_idle);
    @(negedge clk);
    s_tick = 1'b0;
    bus.tx_valid = 1'b1; bus.tx_data = d;
    bus.cfg_dbits = db; bus.cfg_parity = par; bus.cfg_stop = stp;
    #1 check("ready_before_hs", bus.tx_ready, 1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    #1 check("ready_after_hs", bus.tx_ready, 0);
    if (from_idle) begin
      check("tx_idle_n1", tx, 1);
      check("busy_n1", tx_busy, 0);
      @(negedge clk);
      #1;
      check("tx_start_n2", tx, 0);
      check("busy_n2", tx_busy, 1);
      check("ready_n2", bus.tx_ready, 1);
    end else begin
      pending = 1'b1;
    end
  endtask

  // Apply random ticks, comparing the line on every tick against the model.
  task automatic run(input int max_ticks);
    int ticks = 0;
    int cycles = 0;
    bit e, l;
    while (exp_q.size() > 0 && ticks < max_ticks && cycles < 5000) begin
      @(negedge clk);
      s_tick = ($urandom_range(0, 2) == 0);
      if (scramble && !pending) begin
        bus.cfg_dbits  = 4'($urandom_range(0, 15));
        bus.cfg_parity = 2'($urandom_range(0, 3));
        bus.cfg_stop   = 2'($urandom_range(0, 3));
      end
      #1;
      check("ready_level", bus.tx_ready, !pending);
      if (s_tick) begin
        e = exp_q.pop_front();
        l = last_q.pop_front();
        ticks++;
        check("tx_bit", tx, e);
        check("done_tick", tx_done_tick, l);
        check("busy_frame", tx_busy, 1);
        if (l) pending = 1'b0;
      end else begin
        check("done_no_tick", tx_done_tick, 0);
      end
      cycles++;
    end
    @(negedge clk);
    s_tick = 1'b0;
    #1;
    if (ticks < max_ticks) begin
      check("frame_complete", exp_q.size(), 0);
      check("idle_tx", tx, 1);
      check("idle_busy", tx_busy, 0);
      check("idle_ready", bus.tx_ready, 1);
    end
  endtask

  initial begin
    logic [MD-1:0] d;
    int db, par, stp;
    rst = 1'b1; s_tick = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = '0;
    bus.cfg_dbits = 4'd8; bus.cfg_parity = 2'd0; bus.cfg_stop = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done_tick, 0);
    @(negedge clk);
    rst = 1'b0;

    // 8N1, 0x55
    model_frame(8'h55, 8, 0, 0);
    send(8'h55, 4'd8, 2'd0, 2'd0, 1);
    run(1 << 30);

    // 7E2, 0x41
    model_frame(8'h41, 7, 1, 2);
    send(8'h41, 4'd7, 2'd1, 2'd2, 1);
    run(1 << 30);

    // 5O1.5, 0x1F, configuration changes mid-frame
    model_frame(8'h1F, 5, 2, 1);
    send(8'h1F, 4'd5, 2'd2, 2'd1, 1);
    scramble = 1'b1;
    run(1 << 30);
    scramble = 1'b0;

    // Back-to-back 0xA5 then 0x3C with 8N1
    model_frame(8'hA5, 8, 0, 0);
    model_frame(8'h3C, 8, 0, 0);
    send(8'hA5, 4'd8, 2'd0, 2'd0, 1);
    send(8'h3C, 4'd8, 2'd0, 2'd0, 0);
    run(1 << 30);

    // Clamp: 3 and 12 both send a full 8-bit frame
    model_frame(8'hC6, 3, 0, 0);
    send(8'hC6, 4'd3, 2'd0, 2'd0, 1);
    run(1 << 30);
    model_frame(8'h9B, 12, 1, 0);
    send(8'h9B, 4'd12, 2'd1, 2'd0, 1);
    run(1 << 30);

    // Reset in the middle of DATA with a second word pending
    model_frame(8'hF0, 8, 0, 0);
    send(8'hF0, 4'd8, 2'd0, 2'd0, 1);
    run(40);
    send(8'h0F, 4'd8, 2'd0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_ready", bus.tx_ready, 1);
    check("midrst_busy", tx_busy, 0);
    exp_q.delete(); last_q.delete(); pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      s_tick = ($urandom_range(0, 2) == 0);
      #1;
      check("postrst_tx", tx, 1);
      check("postrst_busy", tx_busy, 0);
    end
    $display("reset mid-frame: line stayed idle");

    // Random frames
    for (int k = 0; k < 6; k++) begin
      d   = MD'($urandom);
      db  = $urandom_range(0, 15);
      par = $urandom_range(0, 3);
      stp = $urandom_range(0, 3);
      model_frame(d, db, par, stp);
      send(d, 4'(db), 2'(par), 2'(stp), 1);
      scramble = 1'b1;
      run(1 << 30);
      scramble = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
